// File: rtl/clock_pkg.sv
// Shared types, BCD limits and whole-field BCD helpers for the digital clock
// time-setting logic.
package clock_pkg;

  typedef enum logic [1:0] {
    HOUR = 2'd0,
    MIN  = 2'd1,
    SEC  = 2'd2,
    IDLE = 2'd3
  } state_e;

  localparam logic [7:0] MIN_BCD = 8'h00;
  localparam logic [7:0] MAX_MS  = 8'h59;
  localparam logic [7:0] MAX_H24 = 8'h23;
  localparam logic [7:0] MAX_H12 = 8'h12;
  localparam logic [7:0] MIN_H12 = 8'h01;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi)               return lo;
    else if (v[3:0] >= 4'h9)   return {v[7:4] + 4'h1, 4'h0};
    else                       return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v <= lo)               return hi;
    else if (v[3:0] == 4'h0)   return {v[7:4] - 4'h1, 4'h9};
    else                       return v - 8'h01;
  endfunction

  // Valid BCD digits compare correctly as binary, so range checks are plain compares.
  function automatic logic [7:0] bcd_fix(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v[7:4] > 4'h9 || v[3:0] > 4'h9 || v < lo || v > hi) return lo;
    else                                                    return v;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Raw button conditioner: 2-FF synchroniser, debounce, rising-edge pulse and
// optional auto-repeat while the accepted level stays high.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_per_q, rpt_per_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    db_cnt_d  = '0;
    rpt_cnt_d = rpt_cnt_q;
    rpt_per_d = rpt_per_q;
    pulse_d   = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = sync2_q;
        pulse_d   = sync2_q;
        rpt_cnt_d = '0;
        rpt_per_d = 1'b0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else if (REPEAT_EN && level_q) begin
      // A pending release (synchronised level already low) freezes repeat at once.
      if (rpt_cnt_q == (rpt_per_q ? PER_LAST : DLY_LAST)) begin
        pulse_d   = 1'b1;
        rpt_cnt_d = '0;
        rpt_per_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      rpt_per_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_per_q <= rpt_per_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: edits hour/min/sec as whole BCD fields and hands
// the result to the timekeeper with a one-cycle commit pulse.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter bit          H24             = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter_btn,
  input  logic        next_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic [1:0]  field,
  output logic        setting,
  output logic        commit
);

  localparam logic [7:0]  HOUR_LO  = H24 ? MIN_BCD : MIN_H12;
  localparam logic [7:0]  HOUR_HI  = H24 ? MAX_H24 : MAX_H12;
  localparam logic [23:0] RST_TIME = {(H24 ? 8'h00 : 8'h12), 16'h0000};
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic enter_p, next_p, inc_p, dec_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_enter (.clk(clk), .reset(reset), .btn_raw(enter_btn), .pulse(enter_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_next (.clk(clk), .reset(reset), .btn_raw(next_btn), .pulse(next_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_inc (.clk(clk), .reset(reset), .btn_raw(inc_btn), .pulse(inc_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_dec (.clk(clk), .reset(reset), .btn_raw(dec_btn), .pulse(dec_p));

  state_e           state_q, state_d;
  logic [23:0]      set_time_q, set_time_d;
  logic             setting_q, setting_d;
  logic             commit_q, commit_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic       any_p, step_up, step_dn;
  logic [7:0] fld_cur, fld_new, fld_lo, fld_hi;

  assign any_p   = enter_p | next_p | inc_p | dec_p;
  assign step_up = inc_p & ~dec_p;
  assign step_dn = dec_p & ~inc_p;

  always_comb begin
    state_d    = state_q;
    set_time_d = set_time_q;
    commit_d   = 1'b0;
    tmo_d      = tmo_q;
    fld_lo     = MIN_BCD;
    fld_hi     = MAX_MS;
    case (state_q)
      HOUR:    begin fld_cur = set_time_q[23:16]; fld_lo = HOUR_LO; fld_hi = HOUR_HI; end
      MIN:     fld_cur = set_time_q[15:8];
      default: fld_cur = set_time_q[7:0];
    endcase
    fld_new = fld_cur;
    if (step_up)      fld_new = bcd_inc(fld_cur, fld_lo, fld_hi);
    else if (step_dn) fld_new = bcd_dec(fld_cur, fld_lo, fld_hi);

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (enter_p) begin
          set_time_d = {bcd_fix(cur_time[23:16], HOUR_LO, HOUR_HI),
                        bcd_fix(cur_time[15:8], MIN_BCD, MAX_MS),
                        bcd_fix(cur_time[7:0], MIN_BCD, MAX_MS)};
          state_d    = HOUR;
        end
      end
      default: begin
        case (state_q)
          HOUR:    set_time_d[23:16] = fld_new;
          MIN:     set_time_d[15:8]  = fld_new;
          default: set_time_d[7:0]   = fld_new;
        endcase
        if (any_p) begin
          tmo_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        // Arithmetic above already targets the current field; advancing uses the same edge.
        if (next_p) begin
          case (state_q)
            HOUR:    state_d = MIN;
            MIN:     state_d = SEC;
            default: begin
              state_d  = IDLE;
              commit_d = 1'b1;
            end
          endcase
        end
      end
    endcase
    setting_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      set_time_q <= RST_TIME;
      setting_q  <= 1'b0;
      commit_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      set_time_q <= set_time_d;
      setting_q  <= setting_d;
      commit_q   <= commit_d;
      tmo_q      <= tmo_d;
    end
  end

  assign set_time = set_time_q;
  assign field    = state_q;
  assign setting  = setting_q;
  assign commit   = commit_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a 24h and a 12h instance share the same
// button stimulus; every observed output change is matched against a queue.
module tb_time_set_ctrl;

  typedef struct packed {
    logic [23:0] t;
    logic [1:0]  f;
    logic        s;
    logic        c;
  } obs_t;

  localparam logic [3:0] B_E = 4'b1000;
  localparam logic [3:0] B_N = 4'b0100;
  localparam logic [3:0] B_I = 4'b0010;
  localparam logic [3:0] B_D = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter_btn, next_btn, inc_btn, dec_btn;
  logic [23:0] cur_time;
  logic [23:0] st24, st12;
  logic [1:0]  f24, f12;
  logic        s24, s12, c24, c12;

  obs_t        q24[$];
  obs_t        q12[$];
  obs_t        prev24, prev12, now24, now12;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned commits24 = 0;
  int unsigned commits12 = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  time_set_ctrl #(.H24(1'b1), .DEBOUNCE_CYCLES(2), .REPEAT_DELAY(8),
                  .REPEAT_PERIOD(4), .TIMEOUT_CYCLES(100)) dut24 (
    .clk(clk), .reset(reset), .enter_btn(enter_btn), .next_btn(next_btn),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .cur_time(cur_time),
    .set_time(st24), .field(f24), .setting(s24), .commit(c24));

  time_set_ctrl #(.H24(1'b0), .DEBOUNCE_CYCLES(2), .REPEAT_DELAY(8),
                  .REPEAT_PERIOD(4), .TIMEOUT_CYCLES(100)) dut12 (
    .clk(clk), .reset(reset), .enter_btn(enter_btn), .next_btn(next_btn),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .cur_time(cur_time),
    .set_time(st12), .field(f12), .setting(s12), .commit(c12));

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got t=%h f=%0d s=%0b c=%0b, expected t=%h f=%0d s=%0b c=%0b",
               name, got.t, got.f, got.s, got.c, exp.t, exp.f, exp.s, exp.c);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic exp2(input logic [23:0] t24, input logic [23:0] t12, input logic [1:0] f,
                      input logic s, input logic c);
    q24.push_back(obs_t'({t24, f, s, c}));
    q12.push_back(obs_t'({t12, f, s, c}));
  endtask

  task automatic press(input logic [3:0] m, input int unsigned hold);
    @(negedge clk);
    {enter_btn, next_btn, inc_btn, dec_btn} = m;
    repeat (hold) @(negedge clk);
    {enter_btn, next_btn, inc_btn, dec_btn} = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while ((q24.size() != 0 || q12.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (q24.size() != 0 || q12.size() != 0) begin
      n_fail++;
      $display("FAIL %s: pending changes 24h=%0d 12h=%0d, expected 0",
               name, q24.size(), q12.size());
    end
  endtask

  always @(negedge clk) begin
    now24 = {st24, f24, s24, c24};
    if (mon_en && now24 !== prev24) begin
      if (q24.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb24_unexpected: got t=%h f=%0d s=%0b c=%0b, expected no change",
                 now24.t, now24.f, now24.s, now24.c);
      end else begin
        chk("sb24", now24, q24.pop_front());
      end
    end
    if (mon_en && c24 === 1'b1) commits24++;
    prev24 = now24;
  end

  always @(negedge clk) begin
    now12 = {st12, f12, s12, c12};
    if (mon_en && now12 !== prev12) begin
      if (q12.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb12_unexpected: got t=%h f=%0d s=%0b c=%0b, expected no change",
                 now12.t, now12.f, now12.s, now12.c);
      end else begin
        chk("sb12", now12, q12.pop_front());
      end
    end
    if (mon_en && c12 === 1'b1) commits12++;
    prev12 = now12;
  end

  initial begin
    reset = 1'b1;
    {enter_btn, next_btn, inc_btn, dec_btn} = 4'b0000;
    cur_time = 24'h000000;
    repeat (3) @(negedge clk);
    chk("reset24", {st24, f24, s24, c24}, {24'h000000, 2'd3, 1'b0, 1'b0});
    chk("reset12", {st12, f12, s12, c12}, {24'h120000, 2'd3, 1'b0, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Load and set
    cur_time = 24'h095958;
    exp2(24'h095958, 24'h095958, 2'd0, 1'b1, 1'b0); press(B_E, 4);
    exp2(24'h105958, 24'h105958, 2'd0, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h105958, 24'h105958, 2'd1, 1'b1, 1'b0); press(B_N, 4);
    exp2(24'h105858, 24'h105858, 2'd1, 1'b1, 1'b0); press(B_D, 4);
    exp2(24'h105858, 24'h105858, 2'd2, 1'b1, 1'b0); press(B_N, 4);
    exp2(24'h105859, 24'h105859, 2'd2, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h105800, 24'h105800, 2'd2, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h105800, 24'h105800, 2'd3, 1'b0, 1'b1);
    exp2(24'h105800, 24'h105800, 2'd3, 1'b0, 1'b0); press(B_N, 4);
    drain("load_and_set");

    // Wraps: 23 in 12h mode is out of range and loads as 01
    cur_time = 24'h230009;
    exp2(24'h230009, 24'h010009, 2'd0, 1'b1, 1'b0); press(B_E, 4);
    exp2(24'h000009, 24'h020009, 2'd0, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h230009, 24'h010009, 2'd0, 1'b1, 1'b0); press(B_D, 4);
    exp2(24'h220009, 24'h120009, 2'd0, 1'b1, 1'b0); press(B_D, 4);
    exp2(24'h230009, 24'h010009, 2'd0, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h230009, 24'h010009, 2'd1, 1'b1, 1'b0); press(B_N, 4);
    exp2(24'h235909, 24'h015909, 2'd1, 1'b1, 1'b0); press(B_D, 4);
    exp2(24'h230009, 24'h010009, 2'd1, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h230009, 24'h010009, 2'd2, 1'b1, 1'b0); press(B_N, 4);
    exp2(24'h230010, 24'h010010, 2'd2, 1'b1, 1'b0); press(B_I, 4);
    exp2(24'h230009, 24'h010009, 2'd2, 1'b1, 1'b0); press(B_D, 4);
    exp2(24'h230009, 24'h010009, 2'd3, 1'b0, 1'b1);
    exp2(24'h230009, 24'h010009, 2'd3, 1'b0, 1'b0); press(B_N, 4);
    drain("wraps");

    // Invalid load, then walk to SEC
    cur_time = 24'h2A7F99;
    exp2(24'h000000, 24'h010000, 2'd0, 1'b1, 1'b0); press(B_E, 4);
    exp2(24'h000000, 24'h010000, 2'd1, 1'b1, 1'b0); press(B_N, 4);
    exp2(24'h000000, 24'h010000, 2'd2, 1'b1, 1'b0); press(B_N, 4);
    drain("invalid_load");

    // Debounce glitch and auto-repeat: accept, +8, +12, +16, +20, +24, +28
    press(B_I, 1);
    for (int unsigned k = 1; k <= 7; k++) begin
      exp2({16'h0000, 8'(k)}, {16'h0100, 8'(k)}, 2'd2, 1'b1, 1'b0);
    end
    press(B_I, 30);
    drain("debounce_repeat");

    // Simultaneous events
    press(B_I | B_D, 4);
    exp2(24'h000007, 24'h010007, 2'd3, 1'b0, 1'b1);
    exp2(24'h000007, 24'h010007, 2'd3, 1'b0, 1'b0); press(B_N, 4);
    cur_time = 24'h050000;
    exp2(24'h050000, 24'h050000, 2'd0, 1'b1, 1'b0); press(B_E, 4);
    exp2(24'h060000, 24'h060000, 2'd1, 1'b1, 1'b0); press(B_I | B_N, 4);
    drain("simultaneous");

    // Timeout in MIN: field update 4 edges into the press, abort 100 edges later
    exp2(24'h060000, 24'h060000, 2'd3, 1'b0, 1'b0);
    repeat (83) @(negedge clk);
    chk_bit("tmo_not_early24", s24, 1'b1);
    chk_bit("tmo_not_early12", s12, 1'b1);
    begin
      int unsigned k = 0;
      while (s24 !== 1'b0 && k < 30) begin
        @(negedge clk);
        k++;
      end
    end
    chk_bit("tmo_abort24", s24, 1'b0);
    chk_bit("tmo_abort12", s12, 1'b0);
    drain("timeout");

    // Reset mid-SEC
    exp2(24'h050000, 24'h050000, 2'd0, 1'b1, 1'b0); press(B_E, 4);
    exp2(24'h050000, 24'h050000, 2'd1, 1'b1, 1'b0); press(B_N, 4);
    exp2(24'h050000, 24'h050000, 2'd2, 1'b1, 1'b0); press(B_N, 4);
    drain("reach_sec");
    exp2(24'h000000, 24'h120000, 2'd3, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset24", {st24, f24, s24, c24}, {24'h000000, 2'd3, 1'b0, 1'b0});
    chk("async_reset12", {st12, f12, s12, c12}, {24'h120000, 2'd3, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    drain("reset_mid_edit");

    n_chk++;
    if (commits24 != 3) begin
      n_fail++;
      $display("FAIL commit_cycles24: got %0d, expected 3", commits24);
    end
    n_chk++;
    if (commits12 != 3) begin
      n_fail++;
      $display("FAIL commit_cycles12: got %0d, expected 3", commits12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
